// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  // Stall bus: [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]reserved
  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_IF   = 6'b000011;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  // MEM-stage exception type encodings; 2'b11 is an alias of EXC_EXCP.
  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_EXCP     = 2'b01;
  localparam logic [1:0] EXC_ERTN     = 2'b10;
  localparam logic [1:0] EXC_EXCP_ALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Any non-zero type on a valid MEM instruction triggers a redirect.
  function automatic logic is_exc(input logic valid, input logic [1:0] etype);
    return valid && (etype != EXC_NONE);
  endfunction

  // Only ERTN returns to csr_era; every other redirect goes to csr_eentry.
  function automatic logic is_ertn(input logic [1:0] etype);
    return etype == EXC_ERTN;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline stages and the stall/flush sequencer.
// master = pipeline side (raises requests, consumes stall/flush/redirect),
// slave  = sequencer.
// Signalling: all signals are level-qualified per cycle; there is no
// valid/ready backpressure. new_pc is meaningful only while new_pc_valid=1
// and is driven to zero otherwise.
interface pipeline_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  import pipeline_ctrl_pkg::*;

  logic                  stallreq_if;
  logic                  stallreq_id;
  logic                  stallreq_ex;
  logic                  stallreq_mem;
  logic                  mem_inst_valid;
  logic [1:0]            mem_excepttype;
  logic [ADDR_WIDTH-1:0] csr_eentry;
  logic [ADDR_WIDTH-1:0] csr_era;
  stall_bus_t            stall;
  logic                  flush;
  logic                  new_pc_valid;
  logic [ADDR_WIDTH-1:0] new_pc;
  logic [CNT_WIDTH-1:0]  stall_cycles;
  state_t                dbg_state;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output mem_inst_valid, mem_excepttype, csr_eentry, csr_era,
    input  stall, flush, new_pc_valid, new_pc, stall_cycles, dbg_state
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  mem_inst_valid, mem_excepttype, csr_eentry, csr_era,
    output stall, flush, new_pc_valid, new_pc, stall_cycles, dbg_state
  );

endinterface

// File: rtl/pipeline_ctrl_stall_priority_enc.sv
// Merges the four per-stage stall requests into one stall vector; the
// deepest requesting stage wins and freezes every stage in front of it.
module pipeline_ctrl_stall_priority_enc
  import pipeline_ctrl_pkg::*;
(
  input  logic       req_if,
  input  logic       req_id,
  input  logic       req_ex,
  input  logic       req_mem,
  output stall_bus_t stall
);

  // Priority chain from MEM down to IF.
  always_comb begin
    stall = STALL_NONE;
    if (req_mem)     stall = STALL_MEM;
    else if (req_ex) stall = STALL_EX;
    else if (req_id) stall = STALL_ID;
    else if (req_if) stall = STALL_IF;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: priority stall vector, exception/ERTN
// flush with PC redirect, deferral behind outstanding MEM ops, and a
// saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int FLUSH_HOLD = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  // Last value of the hold counter before returning to IDLE; the redirect
  // cycle itself is the first flush cycle, so HOLD covers FLUSH_HOLD-1.
  localparam logic [3:0] HOLD_LAST = 4'(FLUSH_HOLD - 1);
  localparam state_t     AFTER_REDIRECT = (FLUSH_HOLD > 1) ? ST_HOLD : ST_IDLE;

  state_t                state_q, state_d;
  logic [3:0]            hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic [CNT_WIDTH-1:0]  cnt_q;

  stall_bus_t            req_stall;
  stall_bus_t            stall_d;
  logic                  flush_d;
  logic                  npv_d;
  logic [ADDR_WIDTH-1:0] new_pc_d;
  logic                  exc;
  logic [ADDR_WIDTH-1:0] target;

  assign exc    = is_exc(bus.mem_inst_valid, bus.mem_excepttype);
  assign target = is_ertn(bus.mem_excepttype) ? bus.csr_era : bus.csr_eentry;

  pipeline_ctrl_stall_priority_enc u_enc (
    .req_if  (bus.stallreq_if),
    .req_id  (bus.stallreq_id),
    .req_ex  (bus.stallreq_ex),
    .req_mem (bus.stallreq_mem),
    .stall   (req_stall)
  );

  // Next-state and Mealy outputs; a redirect cycle always has stall=0.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    tgt_d    = tgt_q;
    stall_d  = STALL_NONE;
    flush_d  = 1'b0;
    npv_d    = 1'b0;
    new_pc_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (exc && bus.stallreq_mem) begin
          tgt_d   = target;
          stall_d = STALL_MEM;
          state_d = ST_DRAIN;
        end else if (exc) begin
          flush_d  = 1'b1;
          npv_d    = 1'b1;
          new_pc_d = target;
          hold_d   = 4'd1;
          state_d  = AFTER_REDIRECT;
        end else begin
          stall_d = req_stall;
        end
      end
      ST_DRAIN: begin
        if (bus.stallreq_mem) begin
          stall_d = STALL_MEM;
        end else begin
          flush_d  = 1'b1;
          npv_d    = 1'b1;
          new_pc_d = tgt_q;
          hold_d   = 4'd1;
          state_d  = AFTER_REDIRECT;
        end
      end
      ST_HOLD: begin
        flush_d = 1'b1;
        if (hold_q >= HOLD_LAST) state_d = ST_IDLE;
        else                     hold_d  = hold_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, hold counter, captured target and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      tgt_q   <= tgt_d;
      if (stall_d[0] && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Everything is forced low while reset is held.
  assign bus.stall        = rst ? STALL_NONE : stall_d;
  assign bus.flush        = rst ? 1'b0 : flush_d;
  assign bus.new_pc_valid = rst ? 1'b0 : npv_d;
  assign bus.new_pc       = rst ? '0 : new_pc_d;
  assign bus.stall_cycles = rst ? '0 : cnt_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations,
// randomized traffic against a behavioural model, and counter saturation.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int AW  = 32;
  localparam int FH  = 2;
  localparam int CW  = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pipeline_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  pipeline_ctrl #(.ADDR_WIDTH(AW), .FLUSH_HOLD(FH), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pending: a redirect is waiting for the MEM op to finish.
  // m_hold: remaining extra flush cycles after a redirect.
  // m_cnt: stall cycles seen so far (saturating).
  bit          m_pending;
  logic [31:0] m_tgt;
  int          m_hold;
  int          m_cnt;

  function automatic logic [5:0] req_vector(input bit r_if, r_id, r_ex, r_mem);
    int n;
    n = r_mem ? 5 : r_ex ? 4 : r_id ? 3 : r_if ? 2 : 0;
    return 6'((1 << n) - 1);
  endfunction

  // Compare process: inputs change only just after posedge, so at negedge
  // they are stable; the model advances here to the state after the next edge.
  always @(negedge clk) begin
    logic [5:0]  e_stall;
    logic        e_flush, e_npv;
    logic [31:0] e_pc, tgt;
    int          e_cnt;
    bit          exc, redirect;
    e_stall  = '0;
    e_flush  = 1'b0;
    e_npv    = 1'b0;
    e_pc     = '0;
    e_cnt    = m_cnt;
    redirect = 1'b0;
    if (rst) begin
      e_cnt     = 0;
      m_pending = 1'b0;
      m_hold    = 0;
      m_cnt     = 0;
    end else begin
      exc = bus.mem_inst_valid && (bus.mem_excepttype != 2'b00);
      tgt = (bus.mem_excepttype == 2'b10) ? bus.csr_era : bus.csr_eentry;
      if (m_hold > 0) begin
        e_flush = 1'b1;
        m_hold--;
      end else if (m_pending) begin
        if (bus.stallreq_mem) e_stall = 6'b011111;
        else begin redirect = 1'b1; tgt = m_tgt; end
      end else if (exc) begin
        if (bus.stallreq_mem) begin
          m_pending = 1'b1;
          m_tgt     = tgt;
          e_stall   = 6'b011111;
        end else redirect = 1'b1;
      end else begin
        e_stall = req_vector(bus.stallreq_if, bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem);
      end
      if (redirect) begin
        e_flush   = 1'b1;
        e_npv     = 1'b1;
        e_pc      = tgt;
        m_pending = 1'b0;
        m_hold    = FH - 1;
      end
      if (e_stall[0] && m_cnt < CNT_MAX) m_cnt++;
    end
    chk("model_stall",        64'(bus.stall),        64'(e_stall));
    chk("model_flush",        64'(bus.flush),        64'(e_flush));
    chk("model_new_pc_valid", 64'(bus.new_pc_valid), 64'(e_npv));
    chk("model_new_pc",       64'(bus.new_pc),       64'(e_pc));
    chk("model_stall_cycles", 64'(bus.stall_cycles), 64'(e_cnt));
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stallreq_if    = 1'b0;
    bus.stallreq_id    = 1'b0;
    bus.stallreq_ex    = 1'b0;
    bus.stallreq_mem   = 1'b0;
    bus.mem_inst_valid = 1'b0;
    bus.mem_excepttype = EXC_NONE;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    clear_inputs();
    repeat (cycles) next_cycle();
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    m_pending = 1'b0;
    m_tgt     = '0;
    m_hold    = 0;
    m_cnt     = 0;
    rst       = 1'b1;
    clear_inputs();
    bus.csr_eentry = 32'h1C000040;
    bus.csr_era    = 32'h0;

    // Outputs held at zero during reset.
    bus.stallreq_mem = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_stall", 64'(bus.stall), 64'h0);
      chk("rst_stall_cycles", 64'(bus.stall_cycles), 64'h0);
      next_cycle();
    end
    bus.stallreq_mem = 1'b0;
    rst = 1'b0;

    // EX + IF stall for 4 cycles.
    bus.stallreq_ex = 1'b1;
    bus.stallreq_if = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ex_if_stall", 64'(bus.stall), 64'b001111);
      chk("ex_if_flush", 64'(bus.flush), 64'h0);
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    chk("ex_if_stall_cycles", 64'(bus.stall_cycles), 64'd4);
    next_cycle();

    // Exception, no stalls, two-cycle flush.
    bus.mem_inst_valid = 1'b1;
    bus.mem_excepttype = EXC_EXCP;
    @(negedge clk);
    chk("exc_flush_t0", 64'(bus.flush), 64'h1);
    chk("exc_npv_t0", 64'(bus.new_pc_valid), 64'h1);
    chk("exc_pc_t0", 64'(bus.new_pc), 64'h1C000040);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("exc_flush_t1", 64'(bus.flush), 64'h1);
    chk("exc_npv_t1", 64'(bus.new_pc_valid), 64'h0);
    next_cycle();
    @(negedge clk);
    chk("exc_flush_t2", 64'(bus.flush), 64'h0);
    next_cycle();

    // Exception behind an outstanding MEM op; eentry changes mid-drain.
    bus.mem_inst_valid = 1'b1;
    bus.mem_excepttype = EXC_EXCP;
    bus.stallreq_mem   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) bus.csr_eentry = 32'h1C000080;
      @(negedge clk);
      chk("drain_stall", 64'(bus.stall), 64'b011111);
      chk("drain_flush", 64'(bus.flush), 64'h0);
      next_cycle();
    end
    bus.stallreq_mem = 1'b0;
    @(negedge clk);
    chk("drain_end_flush", 64'(bus.flush), 64'h1);
    chk("drain_end_npv", 64'(bus.new_pc_valid), 64'h1);
    chk("drain_end_pc", 64'(bus.new_pc), 64'h1C000040);
    next_cycle();
    clear_inputs();
    repeat (2) next_cycle();

    // ERTN redirects to era in the same cycle.
    bus.csr_era        = 32'h1C0000A8;
    bus.mem_inst_valid = 1'b1;
    bus.mem_excepttype = EXC_ERTN;
    @(negedge clk);
    chk("ertn_flush", 64'(bus.flush), 64'h1);
    chk("ertn_npv", 64'(bus.new_pc_valid), 64'h1);
    chk("ertn_pc", 64'(bus.new_pc), 64'h1C0000A8);
    next_cycle();
    clear_inputs();
    repeat (2) next_cycle();

    // Flush dominates a concurrent ID stall request.
    bus.mem_inst_valid = 1'b1;
    bus.mem_excepttype = EXC_EXCP_ALT;
    bus.stallreq_id    = 1'b1;
    @(negedge clk);
    chk("flush_vs_id_flush", 64'(bus.flush), 64'h1);
    chk("flush_vs_id_stall", 64'(bus.stall), 64'h0);
    next_cycle();
    clear_inputs();
    repeat (2) next_cycle();

    // Reset in the middle of a drain discards the pending redirect.
    bus.mem_inst_valid = 1'b1;
    bus.mem_excepttype = EXC_EXCP;
    bus.stallreq_mem   = 1'b1;
    repeat (2) next_cycle();
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_stall", 64'(bus.stall), 64'h0);
      chk("post_rst_flush", 64'(bus.flush), 64'h0);
      chk("post_rst_npv", 64'(bus.new_pc_valid), 64'h0);
      chk("post_rst_cnt", 64'(bus.stall_cycles), 64'h0);
      next_cycle();
    end

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 2500; i++) begin
      rst                = ($urandom_range(0, 99) == 0);
      bus.stallreq_if    = ($urandom_range(0, 3) == 0);
      bus.stallreq_id    = ($urandom_range(0, 4) == 0);
      bus.stallreq_ex    = ($urandom_range(0, 5) == 0);
      bus.stallreq_mem   = ($urandom_range(0, 2) == 0);
      bus.mem_inst_valid = ($urandom_range(0, 5) == 0);
      bus.mem_excepttype = 2'($urandom_range(0, 3));
      bus.csr_eentry     = $urandom;
      bus.csr_era        = $urandom;
      next_cycle();
    end
    rst = 1'b0;
    clear_inputs();

    // Counter saturates at all-ones.
    do_reset(1);
    bus.stallreq_if = 1'b1;
    repeat (CNT_MAX + 5) next_cycle();
    @(negedge clk);
    chk("cnt_saturate", 64'(bus.stall_cycles), 64'(CNT_MAX));
    next_cycle();
    clear_inputs();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
